uart_inst_loader: RTL and testbench

- Host-to-core end of the UART link: receives serial bytes on the UART receive pin, packs them little-endian into 32-bit instruction words, and buffers them in a small word FIFO.
- Presents words to the external-instruction conduit (ex_inst) with a valid/ready handshake.
- Sits in the FPGA top beside the PLL/reset logic, clocked by clk_riscv, so a host can stream instructions to the core without the Qsys UART.

---
 rtl/uart_inst_loader_if.sv | 10 +
 rtl/uart_inst_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_inst_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_inst_loader_if.sv
// Instruction conduit between the UART loader (master) and the core's
// external-instruction port (slave).
interface uart_inst_loader_if;
  logic [31:0] ex_inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (output ex_inst, output inst_valid, input inst_ready);
  modport slave  (input ex_inst, input inst_valid, output inst_ready);
endinterface

// File: rtl/uart_inst_loader.sv
// UART receiver packing little-endian bytes into 32-bit instruction words behind a small FIFO.
// Define UART_INST_LOADER_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_inst_loader #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_BYTES = 2
) (
  input  logic                 clk_riscv,
  input  logic                 rst_in,
  input  logic                 uart_rx,
  uart_inst_loader_if.master   ex_if,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_INST_LOADER_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 err_clr
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TO_CYC = IDLE_BYTES * 10 * DIV;
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);

`ifdef UART_INST_LOADER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               rx_meta_q, rx_sync_q, rx_prev_q;
  logic               fall_c, byte_ok_c, push_c, frame_set_c;
  logic [31:0]        push_word_c;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d, occ_left_c;
  logic               pop_c, push_ok_c, ovr_set_c;
  logic [31:0]        ex_inst_q, ex_inst_d;
  logic               inst_valid_q, inst_valid_d;
  logic               frame_err_q, overrun_q;
`ifdef UART_INST_LOADER_PARITY_EN
  logic               parity_bad_q, parity_bad_d, parity_set_c, parity_err_q;
`endif

  // Two-flop synchronizer plus one history flop for start-edge detection; idles high.
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_c      = rx_prev_q & ~rx_sync_q;
  assign push_word_c = {shift_q, word_q};

  // Receive FSM, word assembly and idle-line timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    to_cnt_d    = '0;
    byte_ok_c   = 1'b0;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_INST_LOADER_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_set_c = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_c) begin
          state_d = S_START;
        end else if (byte_idx_q != 2'd0 && rx_sync_q) begin
          if (to_cnt_q == TO_W'(TO_CYC - 1)) byte_idx_d = 2'd0;
          else                               to_cnt_d   = to_cnt_q + TO_W'(1);
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_INST_LOADER_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_INST_LOADER_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d        = '0;
          parity_bad_d = rx_sync_q ^ (^shift_q);
          parity_set_c = parity_bad_d;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_sync_q) frame_set_c = 1'b1;
`ifdef UART_INST_LOADER_PARITY_EN
          else if (!parity_bad_q) byte_ok_c = 1'b1;
`else
          else byte_ok_c = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_ok_c) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    word_d[7:0]   = shift_q;
        2'd1:    word_d[15:8]  = shift_q;
        2'd2:    word_d[23:16] = shift_q;
        default: push_c        = 1'b1;
      endcase
    end
  end

  // FIFO bookkeeping; a pop frees the slot before a same-cycle push is judged.
  always_comb begin
    pop_c        = inst_valid_q & ex_if.inst_ready;
    push_ok_c    = push_c & ((occ_q != OCC_W'(FIFO_DEPTH)) | pop_c);
    ovr_set_c    = push_c & ~push_ok_c;
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_c);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok_c);
    occ_left_c   = occ_q - OCC_W'(pop_c);
    occ_d        = occ_left_c + OCC_W'(push_ok_c);
    inst_valid_d = (occ_d != '0);
    ex_inst_d    = ex_inst_q;
    if (occ_d != '0) ex_inst_d = (occ_left_c == '0) ? push_word_c : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      to_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      ex_inst_q    <= '0;
      inst_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      to_cnt_q     <= to_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      ex_inst_q    <= ex_inst_d;
      inst_valid_q <= inst_valid_d;
      frame_err_q  <= frame_set_c | (frame_err_q & ~err_clr);
      overrun_q    <= ovr_set_c | (overrun_q & ~err_clr);
    end
  end

`ifdef UART_INST_LOADER_PARITY_EN
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_set_c | (parity_err_q & ~err_clr);
    end
  end

  assign parity_err = parity_err_q;
`endif

  // Word storage carries no reset; only occupied slots are ever read.
  always_ff @(posedge clk_riscv) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_word_c;
  end

  assign ex_if.ex_inst    = ex_inst_q;
  assign ex_if.inst_valid = inst_valid_q;
  assign frame_err        = frame_err_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader: table vectors, directed corner cases
// and a randomized byte stream checked against a byte-list reference model.
module tb_uart_inst_loader;
  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned BAUD       = 62_500;
  localparam int unsigned DIV        = CLK_HZ / BAUD;
  localparam int unsigned IDLE_BYTES = 2;
  localparam int unsigned TO_WAIT    = IDLE_BYTES * 10 * DIV + 5;

  logic clk, rst_in, uart_rx, err_clr, frame_err, overrun;
`ifdef UART_INST_LOADER_PARITY_EN
  logic parity_err;
`endif

  uart_inst_loader_if ex_if ();

  uart_inst_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4), .IDLE_BYTES(IDLE_BYTES)
  ) dut (
    .clk_riscv (clk),
    .rst_in    (rst_in),
    .uart_rx   (uart_rx),
    .ex_if     (ex_if),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_INST_LOADER_PARITY_EN
    .parity_err(parity_err),
`endif
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] exp_word;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 1;
  int          vcnt = 0;
  int          stab_bad = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pe = '0;
  logic [31:0] got_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer: ready held low, held high, or random per cycle.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ex_if.inst_ready = 1'b0;
      1:       ex_if.inst_ready = 1'b1;
      default: ex_if.inst_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observer: records accepted words and any head change while stalled.
  always @(negedge clk) begin
    if (ex_if.inst_valid) vcnt <= vcnt + 1;
    if (ex_if.inst_valid && ex_if.inst_ready) got_q.push_back(ex_if.ex_inst);
    if (pv && !pr && ex_if.inst_valid && ex_if.ex_inst !== pe) stab_bad <= stab_bad + 1;
    pv <= ex_if.inst_valid;
    pr <= ex_if.inst_ready;
    pe <= ex_if.ex_inst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d required finish", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    logic [10:0] fr;
    int          n;
`ifdef UART_INST_LOADER_PARITY_EN
    fr = {stop_bit, (^b) ^ par_bad, b, 1'b0};
    n  = 11;
`else
    fr = {1'b1, stop_bit, b, 1'b0};
    n  = 10;
    if (par_bad) $display("note: parity not compiled in");
`endif
    for (int i = 0; i < n; i++) begin
      uart_rx = fr[i];
      repeat (DIV) step();
    end
    uart_rx = 1'b1;
    if (!stop_bit) repeat (DIV) step();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, 1'b0);
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int k = 0;
    while (got_q.size() < target && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(got_q.size()), 32'(target));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
  endtask

  vec_t        vecs [4];
  int          base, v0;
  logic [31:0] ow [5];
  logic [7:0]  part [$];
  logic [31:0] exp_q [$];
  logic        exp_ferr, exp_perr;

  initial begin
    vecs[0] = '{b0: 8'h13, b1: 8'h05, b2: 8'h10, b3: 8'h00, gap: 0,  exp_word: 32'h0010_0513};
    vecs[1] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, gap: 3,  exp_word: 32'hFFFF_FFFF};
    vecs[2] = '{b0: 8'hA5, b1: 8'h5A, b2: 8'h3C, b3: 8'hC3, gap: 17, exp_word: 32'hC33C_5AA5};
    vecs[3] = '{b0: 8'h00, b1: 8'h80, b2: 8'h01, b3: 8'h7E, gap: 40, exp_word: 32'h7E01_8000};

    rst_in  = 1'b0;
    uart_rx = 1'b1;
    err_clr = 1'b0;
    repeat (3) step();
    check("rst_ex_inst", ex_if.ex_inst, 32'h0);
    check("rst_valid", 32'(ex_if.inst_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_in = 1'b1;
    repeat (5) step();

    // Table vectors with an always-ready consumer.
    for (int i = 0; i < 4; i++) begin
      base = got_q.size();
      v0   = vcnt;
      send_byte(vecs[i].b0, 1'b1, 1'b0);
      repeat (vecs[i].gap) step();
      send_byte(vecs[i].b1, 1'b1, 1'b0);
      repeat (vecs[i].gap) step();
      send_byte(vecs[i].b2, 1'b1, 1'b0);
      repeat (vecs[i].gap) step();
      send_byte(vecs[i].b3, 1'b1, 1'b0);
      wait_words(base + 1, 40, "vec_count");
      repeat (3) step();
      check("vec_word", got_q[base], vecs[i].exp_word);
      check("vec_valid_pulse", 32'(vcnt - v0), 32'd1);
      check("vec_frame_err", 32'(frame_err), 32'h0);
    end

    // Five words into a stalled consumer: four kept, fifth overruns.
    for (int i = 0; i < 5; i++) ow[i] = $urandom;
    ready_mode = 0;
    step();
    base = got_q.size();
    for (int i = 0; i < 5; i++) send_word(ow[i]);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_head_valid", 32'(ex_if.inst_valid), 32'h1);
    check("ovr_head_word", ex_if.ex_inst, ow[0]);
    ready_mode = 1;
    wait_words(base + 4, 60, "ovr_drain_count");
    repeat (3) step();
    for (int i = 0; i < 4; i++) check("ovr_order", got_q[base + i], ow[i]);
    check("ovr_drain_total", 32'(got_q.size() - base), 32'd4);
    check("ovr_valid_low", 32'(ex_if.inst_valid), 32'h0);
    check("ovr_hold_last", ex_if.ex_inst, ow[3]);
    pulse_clr();
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Bad stop bit: byte dropped, lane position unchanged.
    base = got_q.size();
    send_byte(8'hAA, 1'b0, 1'b0);
    check("ferr_set", 32'(frame_err), 32'h1);
    send_word(32'h0403_0201);
    wait_words(base + 1, 40, "ferr_count");
    check("ferr_word", got_q[base], 32'h0403_0201);
    pulse_clr();
    check("ferr_cleared", 32'(frame_err), 32'h0);

    // Short low glitch is ignored.
    base = got_q.size();
    uart_rx = 1'b0;
    repeat (4) step();
    uart_rx = 1'b1;
    repeat (3 * DIV) step();
    check("glitch_no_err", 32'(frame_err), 32'h0);
    check("glitch_no_word", 32'(got_q.size() - base), 32'd0);
    send_word(32'hDEAD_BEEF);
    wait_words(base + 1, 40, "glitch_count");
    check("glitch_word", got_q[base], 32'hDEAD_BEEF);

    // Idle timeout discards a partial word.
    base = got_q.size();
    send_byte(8'h5E, 1'b1, 1'b0);
    send_byte(8'h6F, 1'b1, 1'b0);
    repeat (TO_WAIT) step();
    send_word(32'h4433_2211);
    wait_words(base + 1, 40, "timeout_count");
    repeat (5) step();
    check("timeout_word", got_q[base], 32'h4433_2211);
    check("timeout_single", 32'(got_q.size() - base), 32'd1);

    // Reset in the middle of a frame with a partial word and a sticky error pending.
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    check("pre_rst_ferr", 32'(frame_err), 32'h1);
    uart_rx = 1'b0;
    repeat (DIV) step();
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'(i % 2 == 0);
      repeat (DIV) step();
    end
    rst_in  = 1'b0;
    uart_rx = 1'b1;
    repeat (3) step();
    check("mid_rst_ex_inst", ex_if.ex_inst, 32'h0);
    check("mid_rst_valid", 32'(ex_if.inst_valid), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    rst_in = 1'b1;
    repeat (2 * DIV) step();
    base = got_q.size();
    send_word(32'hD4C3_B2A1);
    wait_words(base + 1, 40, "post_rst_count");
    check("post_rst_word", got_q[base], 32'hD4C3_B2A1);

`ifdef UART_INST_LOADER_PARITY_EN
    // Bad parity drops the byte; correct parity accepts it.
    base = got_q.size();
    send_byte(8'h03, 1'b1, 1'b1);
    check("par_err_set", 32'(parity_err), 32'h1);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b0);
    send_byte(8'h0B, 1'b1, 1'b0);
    send_byte(8'h0C, 1'b1, 1'b0);
    wait_words(base + 1, 40, "par_count");
    check("par_word", got_q[base], 32'h0C0B_0A03);
    pulse_clr();
    check("par_cleared", 32'(parity_err), 32'h0);
`endif

    // Random byte stream, random consumer, reference model on byte lists.
    pulse_clr();
    ready_mode = 2;
    base     = got_q.size();
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       stop_ok, par_bad;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_INST_LOADER_PARITY_EN
      par_bad = ($urandom_range(0, 7) == 0);
`else
      par_bad = 1'b0;
`endif
      send_byte(b, stop_ok, par_bad);
      repeat ($urandom_range(0, 20)) step();
      if (!stop_ok) exp_ferr = 1'b1;
      if (par_bad)  exp_perr = 1'b1;
      if (stop_ok && !par_bad) begin
        part.push_back(b);
        if (part.size() == 4) begin
          exp_q.push_back({part[3], part[2], part[1], part[0]});
          part.delete();
        end
      end
    end
    wait_words(base + exp_q.size(), 400, "rand_count");
    foreach (exp_q[i]) check("rand_word", got_q[base + i], exp_q[i]);
    check("rand_frame_err", 32'(frame_err), 32'(exp_ferr));
`ifdef UART_INST_LOADER_PARITY_EN
    check("rand_parity_err", 32'(parity_err), 32'(exp_perr));
`endif
    ready_mode = 1;
    repeat (5) step();
    check("head_stable_when_stalled", 32'(stab_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
